div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
Execute-stage controller that issues DIV/DIVU/REM/REMU to the combinational 32-bit divider and returns its result to the pipeline. It latches the operands and holds them stable on the divider inputs for LATENCY cycles, so the array can be timed as a multicycle path. It also resolves RISC-V divide-by-zero and signed-overflow directly, then presents the quotient or remainder on a valid/ready response port.

Parameters:
LATENCY, 4, cycles the divider inputs are held before the output is sampled; legal range 1..15
TAG_W, 5, width of the destination-register tag carried alongside each request

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of any in-flight operation
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
req_rs1  input  32  dividend
req_rs2  input  32  divisor
req_tag  input  TAG_W  destination tag
div_a  output  32  divider dividend, driven from the latched register
div_b  output  32  divider divisor, driven from the latched register
div_sign  output  1  1 = signed operation
div_f  input  32  divider quotient
div_rem  input  32  divider remainder
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts the result
resp_data  output  32  quotient or remainder
resp_tag  output  TAG_W  tag of the request
busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states are IDLE, WAIT and DONE. Reset puts the FSM in IDLE and clears every output and internal register to 0.
- req_ready = (state==IDLE) & ~flush. A request is accepted when req_valid & req_ready.
- On accept: latch rs1, rs2, funct3 and tag.
  - div_sign = ~funct3[0].
  - Result select: funct3[1] chooses remainder, otherwise quotient.
- Special cases, resolved at accept, go to DONE in the next cycle without using the divider:
  - rs2==0: quotient 0xFFFFFFFF, remainder rs1. Applies to both signed and unsigned ops.
  - Signed, rs1==0x80000000 and rs2==0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Any other request goes to WAIT with cnt=LATENCY-1.
- WAIT: div_a, div_b and div_sign stay constant.
  - cnt!=0: decrement cnt.
  - cnt==0: register the selected div_f or div_rem into resp_data, then go to DONE.
- Latency from the accept cycle T: normal ops give resp_valid in cycle T+LATENCY+1; special cases give resp_valid in cycle T+1.
- DONE: resp_valid=1. resp_data and resp_tag stay stable until resp_ready; then go to IDLE.
  - A new request can be accepted in the cycle after the handshake.
  - No back-to-back accept in the same cycle as the handshake.
- An illegal funct3 (bit2==0) is still accepted and returns resp_data=0 after the normal latency.
- flush has priority over every other event:
  - Next state is IDLE; the pending result is dropped.
  - resp_valid deasserts in the next cycle.
  - A request presented in the same cycle is not accepted.
- rst_n asserted in mid-operation returns everything to reset values immediately; no response is produced.
- cnt is 4 bits wide and never wraps; LATENCY==1 means WAIT lasts exactly one cycle.

Optional Feature:
DIV_ISSUE_RESULT_CACHE_EN:
- With the macro defined, the controller keeps the last completed normal op:
  - stored: rs1, rs2, signedness, quotient, remainder, plus a valid bit cleared by reset only;
  - the cache is updated on entry to DONE from WAIT.
- A new accept with matching rs1, rs2 and signedness goes straight to DONE and returns the cached quotient or remainder at T+1. This covers the DIV-then-REM idiom.
- Flush does not invalidate the cache.
- With the macro undefined, no cache logic exists and every normal op takes the full latency.

Test Plan:
- LATENCY=4, DIVU 100/7, tag 3, accept at T -> resp_valid at T+5, resp_data=14, resp_tag=3.
- REM rs1=0xFFFFFFF9 (-7), rs2=2 -> resp_data=0xFFFFFFFF (-1). DIV on the same operands -> 0xFFFFFFFD (-3).
- DIV 5/0 -> resp_data=0xFFFFFFFF at T+1. REMU 5/0 -> 5 at T+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM on the same operands -> 0.
- Hold resp_ready=0 for 3 cycles in DONE -> resp_valid, resp_data and resp_tag stay constant; req_ready=0. Raise resp_ready -> req_ready=1 in the following cycle.
- Pulse flush in the 2nd WAIT cycle -> no response, IDLE next cycle. Next DIVU 9/3 -> 3 with full latency.
- Drop rst_n in WAIT -> all outputs 0 immediately. With DIV_ISSUE_RESULT_CACHE_EN, DIVU 100/7 then REMU 100/7 -> second response is 2 at T+1.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Issue/response bundle between the execute pipeline, div_issue_ctrl and the combinational divider.
// The master side is the pipeline plus divider array; the slave side is the controller.
interface div_issue_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_sign;
  logic [31:0]      div_f;
  logic [31:0]      div_rem;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  modport master (
    output flush, req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
           div_f, div_rem,
    input  req_ready, div_a, div_b, div_sign, resp_valid, resp_data, resp_tag, busy
  );

  modport slave (
    input  flush, req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
           div_f, div_rem,
    output req_ready, div_a, div_b, div_sign, resp_valid, resp_data, resp_tag, busy
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Multicycle issue controller for a combinational 32-bit divider (DIV/DIVU/REM/REMU).
// Optional last-result cache enabled by defining DIV_ISSUE_RESULT_CACHE_EN.
module div_issue_ctrl #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  div_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             sign_q, sign_d;
  logic             rem_sel_q, rem_sel_d;
  logic             legal_q, legal_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             can_accept;
  logic             is_dz;
  logic             is_ovf;

`ifdef DIV_ISSUE_RESULT_CACHE_EN
  logic        cvalid_q, cvalid_d;
  logic [31:0] ca_q, ca_d;
  logic [31:0] cb_q, cb_d;
  logic        csign_q, csign_d;
  logic [31:0] cquo_q, cquo_d;
  logic [31:0] crem_q, crem_d;
  logic        hit;

  // Only legal ops may hit; illegal funct3 must still take the full latency.
  assign hit = bus.req_funct3[2] & cvalid_q & (bus.req_rs1 == ca_q) &
               (bus.req_rs2 == cb_q) & (~bus.req_funct3[0] == csign_q);
`endif

  assign can_accept = (state_q == IDLE) & ~bus.flush;
  assign is_dz      = bus.req_funct3[2] & (bus.req_rs2 == 32'h0);
  assign is_ovf     = bus.req_funct3[2] & ~bus.req_funct3[0] &
                      (bus.req_rs1 == 32'h8000_0000) & (bus.req_rs2 == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      legal_q   <= 1'b0;
      tag_q     <= '0;
      data_q    <= '0;
`ifdef DIV_ISSUE_RESULT_CACHE_EN
      cvalid_q  <= 1'b0;
      ca_q      <= '0;
      cb_q      <= '0;
      csign_q   <= 1'b0;
      cquo_q    <= '0;
      crem_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      rem_sel_q <= rem_sel_d;
      legal_q   <= legal_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
`ifdef DIV_ISSUE_RESULT_CACHE_EN
      cvalid_q  <= cvalid_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
      csign_q   <= csign_d;
      cquo_q    <= cquo_d;
      crem_q    <= crem_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    rem_sel_d = rem_sel_q;
    legal_d   = legal_q;
    tag_d     = tag_q;
    data_d    = data_q;
`ifdef DIV_ISSUE_RESULT_CACHE_EN
    cvalid_d  = cvalid_q;
    ca_d      = ca_q;
    cb_d      = cb_q;
    csign_d   = csign_q;
    cquo_d    = cquo_q;
    crem_d    = crem_q;
`endif
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && can_accept) begin
            a_d       = bus.req_rs1;
            b_d       = bus.req_rs2;
            sign_d    = ~bus.req_funct3[0];
            rem_sel_d = bus.req_funct3[1];
            legal_d   = bus.req_funct3[2];
            tag_d     = bus.req_tag;
            if (is_dz) begin
              data_d  = bus.req_funct3[1] ? bus.req_rs1 : 32'hFFFF_FFFF;
              state_d = DONE;
            end else if (is_ovf) begin
              data_d  = bus.req_funct3[1] ? 32'h0 : 32'h8000_0000;
              state_d = DONE;
            end
`ifdef DIV_ISSUE_RESULT_CACHE_EN
            else if (hit) begin
              data_d  = bus.req_funct3[1] ? crem_q : cquo_q;
              state_d = DONE;
            end
`endif
            else begin
              cnt_d   = CNT_INIT;
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            data_d  = legal_q ? (rem_sel_q ? bus.div_rem : bus.div_f) : 32'h0;
            state_d = DONE;
`ifdef DIV_ISSUE_RESULT_CACHE_EN
            cvalid_d = 1'b1;
            ca_d     = a_q;
            cb_d     = b_q;
            csign_d  = sign_q;
            cquo_d   = bus.div_f;
            crem_d   = bus.div_rem;
`endif
          end
        end
        DONE: begin
          if (bus.resp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = can_accept;
    bus.resp_valid = (state_q == DONE);
    bus.busy       = (state_q != IDLE);
    bus.div_a      = a_q;
    bus.div_b      = b_q;
    bus.div_sign   = sign_q;
    bus.resp_data  = data_q;
    bus.resp_tag   = tag_q;
  end
endmodule
